// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and the fetch-stage state encoding
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_ERR  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/ifu_fetch_if.sv
// rtl/ifu_fetch_if.sv - instruction-memory and decode handshakes of the fetch stage
interface ifu_fetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] inst_out;
    logic        inst_valid;
    logic        inst_ready;

    modport master (
        output imem_req, imem_addr, inst_out, inst_valid,
        input  imem_gnt, imem_rvalid, imem_rdata, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_out, inst_valid,
        output imem_gnt, imem_rvalid, imem_rdata, inst_ready
    );

endinterface

// File: rtl/ifu_fetch_pc_reg.sv
// rtl/ifu_fetch_pc_reg.sv - enable register with synchronous active-low reset value
module pc_reg #(
    parameter int           W         = 32,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - fetch stage owning the PC; IFU_ALIGN_CHK_EN enables misaligned-PC trapping
module ifu_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] pc_out,
    input  logic [ADDR_W-1:0] npc_in,
    output logic              fetch_err,
    ifu_fetch_if.master       bus
);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       inst_q;
    logic              valid_q;
    logic              consume;

    // The PC only moves when decode takes the held instruction, so the
    // next-PC logic always evaluates against a stable value.
    assign consume = (state_q == S_HOLD) && bus.inst_ready;

    pc_reg #(
        .W         (ADDR_W),
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (consume),
        .d     (npc_in),
        .q     (pc_q)
    );

`ifdef IFU_ALIGN_CHK_EN
    logic err_q;
    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_REQ;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
`ifdef IFU_ALIGN_CHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_REQ: begin
                    if (bus.imem_gnt) begin
                        if (bus.imem_rvalid) begin
                            inst_q  <= bus.imem_rdata;
                            valid_q <= 1'b1;
                            state_q <= S_HOLD;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rvalid) begin
                        inst_q  <= bus.imem_rdata;
                        valid_q <= 1'b1;
                        state_q <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus.inst_ready) begin
                        valid_q <= 1'b0;
`ifdef IFU_ALIGN_CHK_EN
                        if (npc_in[1:0] != 2'b00) begin
                            err_q   <= 1'b1;
                            state_q <= S_ERR;
                        end else begin
                            state_q <= S_REQ;
                        end
`else
                        state_q <= S_REQ;
`endif
                    end
                end
`ifdef IFU_ALIGN_CHK_EN
                S_ERR: state_q <= S_ERR;
`endif
                default: state_q <= S_REQ;
            endcase
        end
    end

    assign pc_out         = pc_q;
    assign bus.imem_req   = (state_q == S_REQ);
    assign bus.imem_addr  = pc_q;
    assign bus.inst_out   = inst_q;
    assign bus.inst_valid = valid_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - scoreboard bench for ifu_fetch; honours IFU_ALIGN_CHK_EN
module tb_ifu_fetch;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_out;
    logic [31:0] npc_in;
    logic        fetch_err;

    ifu_fetch_if bus_if ();

    ifu_fetch dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pc_out    (pc_out),
        .npc_in    (npc_in),
        .fetch_err (fetch_err),
        .bus       (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_inst_q[$];
    string       chk_name_q[$];
    int          chk_sel_q[$];
    logic [31:0] chk_exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // sel: 0 pc_out, 1 imem_req, 2 imem_addr, 3 inst_valid, 4 inst_out, 5 fetch_err, 6 scoreboard depth
    task automatic chk(input string name, input int sel, input logic [31:0] exp);
        chk_name_q.push_back(name);
        chk_sel_q.push_back(sel);
        chk_exp_q.push_back(exp);
    endtask

    task automatic expect_inst(input logic [31:0] pc, input logic [31:0] inst);
        exp_pc_q.push_back(pc);
        exp_inst_q.push_back(inst);
    endtask

    always @(negedge clk) begin : monitor
        logic [31:0] epc, einst, act, exp;
        string       name;
        int          sel;
        if (rst_n && bus_if.inst_valid && bus_if.inst_ready) begin
            tests++;
            if (exp_pc_q.size() == 0) begin
                fails++;
                $display("FAIL consume_unexpected: pc=%h inst=%h, required no pending instruction",
                         pc_out, bus_if.inst_out);
            end else begin
                epc   = exp_pc_q.pop_front();
                einst = exp_inst_q.pop_front();
                if (pc_out !== epc || bus_if.inst_out !== einst) begin
                    fails++;
                    $display("FAIL consume: pc=%h inst=%h, required pc=%h inst=%h",
                             pc_out, bus_if.inst_out, epc, einst);
                end
            end
        end
        while (chk_sel_q.size() > 0) begin
            name = chk_name_q.pop_front();
            sel  = chk_sel_q.pop_front();
            exp  = chk_exp_q.pop_front();
            case (sel)
                0:       act = pc_out;
                1:       act = {31'b0, bus_if.imem_req};
                2:       act = bus_if.imem_addr;
                3:       act = {31'b0, bus_if.inst_valid};
                4:       act = bus_if.inst_out;
                5:       act = {31'b0, fetch_err};
                default: act = exp_pc_q.size();
            endcase
            tests++;
            if (act !== exp) begin
                fails++;
                $display("FAIL %s: got %h, required %h", name, act, exp);
            end
        end
    end

    initial begin
        rst_n              = 1'b0;
        npc_in             = 32'h0;
        bus_if.imem_gnt    = 1'b0;
        bus_if.imem_rvalid = 1'b0;
        bus_if.imem_rdata  = 32'h0;
        bus_if.inst_ready  = 1'b0;

        tick(); tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("rst_pc", 0, 32'h3000);
        chk("rst_req", 1, 32'h1);
        chk("rst_addr", 2, 32'h3000);
        chk("rst_valid", 3, 32'h0);
        chk("rst_inst", 4, 32'h0);
        chk("rst_err", 5, 32'h0);

        // zero-wait fetch
        bus_if.imem_gnt = 1'b1; bus_if.imem_rvalid = 1'b1; bus_if.imem_rdata = 32'h2008_0005;
        expect_inst(32'h3000, 32'h2008_0005);
        tick();
        bus_if.imem_gnt = 1'b0; bus_if.imem_rvalid = 1'b0;
        chk("zw_valid", 3, 32'h1);
        chk("zw_inst", 4, 32'h2008_0005);
        chk("zw_req", 1, 32'h0);
        bus_if.inst_ready = 1'b1; npc_in = 32'h3004;
        tick();
        bus_if.inst_ready = 1'b0;
        chk("zw_pc", 0, 32'h3004);
        chk("zw_nreq", 1, 32'h1);
        chk("zw_addr", 2, 32'h3004);
        chk("zw_cvalid", 3, 32'h0);

        // wait states then backpressure; rvalid and npc_in noise while holding
        bus_if.imem_gnt = 1'b1;
        tick();
        bus_if.imem_gnt = 1'b0;
        for (int i = 1; i < 4; i++) begin
            chk("ws_req", 1, 32'h0);
            chk("ws_valid", 3, 32'h0);
            tick();
        end
        bus_if.imem_rvalid = 1'b1; bus_if.imem_rdata = 32'h0041_8193;
        expect_inst(32'h3004, 32'h0041_8193);
        tick();
        for (int i = 0; i < 3; i++) begin
            bus_if.imem_rdata = 32'hBAD0_0000 + i;
            npc_in = 32'h1234_0000 + i;
            chk("bp_valid", 3, 32'h1);
            chk("bp_inst", 4, 32'h0041_8193);
            chk("bp_pc", 0, 32'h3004);
            chk("bp_req", 1, 32'h0);
            tick();
        end
        bus_if.imem_rvalid = 1'b0;
        bus_if.inst_ready = 1'b1; npc_in = 32'h2FF0;
        tick();
        bus_if.inst_ready = 1'b0;
        chk("br_addr", 2, 32'h2FF0);
        chk("br_req", 1, 32'h1);

        // no grant: request stays up at the same address
        tick();
        chk("nogt_req", 1, 32'h1);
        chk("nogt_addr", 2, 32'h2FF0);

        // jump
        bus_if.imem_gnt = 1'b1; bus_if.imem_rvalid = 1'b1; bus_if.imem_rdata = 32'h0000_006F;
        expect_inst(32'h2FF0, 32'h0000_006F);
        tick();
        bus_if.imem_gnt = 1'b0; bus_if.imem_rvalid = 1'b0;
        bus_if.inst_ready = 1'b1; npc_in = 32'h3000_0040;
        tick();
        bus_if.inst_ready = 1'b0;
        chk("jmp_addr", 2, 32'h3000_0040);
        chk("jmp_pc", 0, 32'h3000_0040);

        // top of address space, then wrap to zero
        bus_if.imem_gnt = 1'b1; bus_if.imem_rvalid = 1'b1; bus_if.imem_rdata = 32'h0000_0013;
        expect_inst(32'h3000_0040, 32'h0000_0013);
        tick();
        bus_if.imem_gnt = 1'b0; bus_if.imem_rvalid = 1'b0;
        bus_if.inst_ready = 1'b1; npc_in = 32'hFFFF_FFFC;
        tick();
        bus_if.inst_ready = 1'b0;
        chk("top_addr", 2, 32'hFFFF_FFFC);
        bus_if.imem_gnt = 1'b1; bus_if.imem_rvalid = 1'b1; bus_if.imem_rdata = 32'h0010_0093;
        expect_inst(32'hFFFF_FFFC, 32'h0010_0093);
        tick();
        bus_if.imem_gnt = 1'b0; bus_if.imem_rvalid = 1'b0;
        bus_if.inst_ready = 1'b1; npc_in = 32'h0;
        tick();
        bus_if.inst_ready = 1'b0;
        chk("wrap_addr", 2, 32'h0);
        chk("wrap_req", 1, 32'h1);

        // reset while waiting; late rvalid must be dropped
        bus_if.imem_gnt = 1'b1;
        tick();
        bus_if.imem_gnt = 1'b0;
        chk("mr_wait_req", 1, 32'h0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus_if.imem_rvalid = 1'b1; bus_if.imem_rdata = 32'hDEAD_BEEF;
        tick();
        bus_if.imem_rvalid = 1'b0;
        chk("mr_valid", 3, 32'h0);
        chk("mr_inst", 4, 32'h0);
        chk("mr_addr", 2, 32'h3000);
        chk("mr_req", 1, 32'h1);

        // misaligned next PC
        bus_if.imem_gnt = 1'b1; bus_if.imem_rvalid = 1'b1; bus_if.imem_rdata = 32'h0000_0067;
        expect_inst(32'h3000, 32'h0000_0067);
        tick();
        bus_if.imem_gnt = 1'b0; bus_if.imem_rvalid = 1'b0;
        bus_if.inst_ready = 1'b1; npc_in = 32'h3006;
        tick();
        bus_if.inst_ready = 1'b0;
        chk("mis_pc", 0, 32'h3006);
`ifdef IFU_ALIGN_CHK_EN
        for (int i = 0; i < 3; i++) begin
            bus_if.imem_gnt = 1'b1; bus_if.imem_rvalid = 1'b1;
            chk("mis_err", 5, 32'h1);
            chk("mis_req", 1, 32'h0);
            chk("mis_valid", 3, 32'h0);
            tick();
        end
        bus_if.imem_gnt = 1'b0; bus_if.imem_rvalid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mis_rst_err", 5, 32'h0);
        chk("mis_rst_req", 1, 32'h1);
`else
        chk("mis_addr", 2, 32'h3006);
        chk("mis_err", 5, 32'h0);
        chk("mis_req", 1, 32'h1);
`endif

        chk("sb_empty", 6, 32'h0);
        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
